// File: rtl/connect_pkg.sv
// Shared definitions for the connect_* stream fabric blocks (merge, fork, schedulers).
package connect_pkg;

  localparam int CONNECT_DATA_WIDTH = 32;

  // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/connect_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo CONNECT_NUM.
module connect_rr_pick
  import connect_pkg::*;
#(
  parameter int CONNECT_NUM = 3,
  parameter int INDEX_WIDTH = (clog2(CONNECT_NUM) < 1) ? 1 : clog2(CONNECT_NUM)
) (
  input  logic [CONNECT_NUM-1:0] req,
  input  logic [INDEX_WIDTH-1:0] ptr,
  output logic [INDEX_WIDTH-1:0] grant,
  output logic                   any
);

  int idx;

  // Scan from the farthest offset back toward ptr so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    any   = |req;
    for (int k = CONNECT_NUM - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= CONNECT_NUM) idx = idx - CONNECT_NUM;
      if (req[idx]) grant = INDEX_WIDTH'(idx);
    end
  end

endmodule

// File: rtl/connect_merge_rr.sv
// Round-robin N-to-1 stream merger with a 2-entry registered output buffer.
// Each word carries the index of the producer it was accepted from.
module connect_merge_rr
  import connect_pkg::*;
#(
  parameter int DATA_WIDTH  = CONNECT_DATA_WIDTH,
  parameter int CONNECT_NUM = 3,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
  output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
  output logic                              SEND_VALID,
  output logic [DATA_WIDTH-1:0]             SEND_DATA,
  output logic [INDEX_WIDTH-1:0]            SEND_INDEX,
  input  logic                              SEND_READY
);

  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] grant;
  logic [INDEX_WIDTH-1:0] ptr_next;
  logic [1:0]             count;
  logic [1:0]             count_next;
  logic                   any;
  logic                   space;
  logic                   push;
  logic                   pop;
  logic [DATA_WIDTH-1:0]  grant_data;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [DATA_WIDTH-1:0]  tail_data;
  logic [INDEX_WIDTH-1:0] head_index;
  logic [INDEX_WIDTH-1:0] tail_index;

  connect_rr_pick #(
    .CONNECT_NUM (CONNECT_NUM),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_pick (
    .req   (RECEIVE_VALID),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  // Space comes from registered count only, so SEND_READY never reaches RECEIVE_READY.
  assign space = (count < 2'd2);
  assign push  = space & any & ~RST;
  assign pop   = SEND_VALID & SEND_READY;

  assign grant_data = RECEIVE_DATA[DATA_WIDTH*int'(grant) +: DATA_WIDTH];
  assign ptr_next   = (int'(grant) == CONNECT_NUM - 1) ? '0 : grant + 1'b1;

  always_comb begin
    RECEIVE_READY = '0;
    if (push) RECEIVE_READY[grant] = 1'b1;
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Head is the output register itself; tail only holds the second word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count      <= 2'd0;
      ptr        <= '0;
      SEND_VALID <= 1'b0;
      head_data  <= '0;
      head_index <= '0;
      tail_data  <= '0;
      tail_index <= '0;
    end else begin
      count      <= count_next;
      SEND_VALID <= (count_next != 2'd0);
      if (push) ptr <= ptr_next;
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        head_data  <= grant_data;
        head_index <= grant;
      end else if (pop) begin
        head_data  <= tail_data;
        head_index <= tail_index;
      end
      if (push && count == 2'd1 && !pop) begin
        tail_data  <= grant_data;
        tail_index <= grant;
      end
    end
  end

  assign SEND_DATA  = head_data;
  assign SEND_INDEX = head_index;

endmodule

// File: tb/tb_connect_merge_rr.sv
// Bench for connect_merge_rr: directed vector table plus a queue scoreboard with a reference arbiter.
module tb_connect_merge_rr;

  localparam int DW = 32;
  localparam int N  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    rv;
  logic [DW*N-1:0] rd;
  logic [N-1:0]    rdy;
  logic            sv;
  logic [DW-1:0]   sd;
  logic [IW-1:0]   si;
  logic            sr;

  connect_merge_rr #(
    .DATA_WIDTH  (DW),
    .CONNECT_NUM (N),
    .INDEX_WIDTH (IW)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .RECEIVE_VALID (rv),
    .RECEIVE_DATA  (rd),
    .RECEIVE_READY (rdy),
    .SEND_VALID    (sv),
    .SEND_DATA     (sd),
    .SEND_INDEX    (si),
    .SEND_READY    (sr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } word_t;

  typedef struct {
    logic [N-1:0]  rv;
    logic          sr;
    logic [N-1:0]  erdy;
    logic          esv;
    logic [IW-1:0] eidx;
    logic [DW-1:0] edata;
  } vec_t;

  word_t sb[$];
  int    m_cnt;
  int    m_ptr;
  int    n_vec;
  int    n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock: check at negedge against the model (and optional table row), advance at posedge.
  task automatic cyc(input bit use_tv, input vec_t tv);
    int       g;
    bit       push;
    bit       pop;
    logic [N-1:0] er;
    word_t    w;
    @(negedge clk);
    push = 0;
    pop  = 0;
    g    = 0;
    if (rst) begin
      chk("ready_in_reset", 32'(rdy), 32'd0);
    end else begin
      g    = pick(rv, m_ptr);
      push = (m_cnt < 2) && (g >= 0);
      er   = push ? N'(1 << g) : '0;
      chk("ready", 32'(rdy), 32'(er));
      chk("send_valid", 32'(sv), 32'(m_cnt > 0));
      if (m_cnt > 0) begin
        chk("send_data", sd, sb[0].data);
        chk("send_index", 32'(si), 32'(sb[0].idx));
      end
      pop = (m_cnt > 0) && sr;
      if (use_tv) begin
        chk("tbl_ready", 32'(rdy), 32'(tv.erdy));
        chk("tbl_send_valid", 32'(sv), 32'(tv.esv));
        if (tv.esv) begin
          chk("tbl_send_index", 32'(si), 32'(tv.eidx));
          chk("tbl_send_data", sd, tv.edata);
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_ptr = 0;
      sb.delete();
    end else begin
      if (pop) w = sb.pop_front();
      if (push) begin
        w.data = rd[DW*g +: DW];
        w.idx  = IW'(g);
        sb.push_back(w);
        m_ptr = (g + 1) % N;
      end
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
    #1;
  endtask

  vec_t tbl[18];
  vec_t none;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    m_cnt = 0;
    m_ptr = 0;
    none  = '{default: '0};

    tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b0, 2'd0, 32'h000};
    tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 32'h100};
    tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 32'h101};
    tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 32'h102};
    tbl[4]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 32'h100};
    tbl[5]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 32'h101};
    tbl[6]  = '{3'b101, 1'b1, 3'b001, 1'b1, 2'd2, 32'h102};
    tbl[7]  = '{3'b101, 1'b1, 3'b100, 1'b1, 2'd0, 32'h100};
    tbl[8]  = '{3'b101, 1'b1, 3'b001, 1'b1, 2'd2, 32'h102};
    tbl[9]  = '{3'b101, 1'b1, 3'b100, 1'b1, 2'd0, 32'h100};
    tbl[10] = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd2, 32'h102};
    tbl[11] = '{3'b111, 1'b0, 3'b001, 1'b0, 2'd0, 32'h000};
    tbl[12] = '{3'b111, 1'b0, 3'b010, 1'b1, 2'd0, 32'h100};
    tbl[13] = '{3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 32'h100};
    tbl[14] = '{3'b111, 1'b1, 3'b000, 1'b1, 2'd0, 32'h100};
    tbl[15] = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 32'h101};
    tbl[16] = '{3'b000, 1'b1, 3'b000, 1'b1, 2'd2, 32'h102};
    tbl[17] = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 32'h000};

    rst = 1'b1;
    rv  = 3'b111;
    sr  = 1'b0;
    for (int i = 0; i < N; i++) rd[DW*i +: DW] = 32'h100 + i;
    cyc(0, none);
    cyc(0, none);
    chk("reset_send_valid", 32'(sv), 32'd0);
    chk("reset_send_index", 32'(si), 32'd0);
    chk("reset_send_data", sd, 32'd0);
    rst = 1'b0;

    // Round-robin, idle skipping, backpressure and drain
    for (int i = 0; i < 18; i++) begin
      rv = tbl[i].rv;
      sr = tbl[i].sr;
      cyc(1, tbl[i]);
    end

    // Head must hold while the consumer stalls
    rv = 3'b010;
    sr = 1'b0;
    cyc(0, none);
    rv = 3'b000;
    for (int i = 0; i < 5; i++) begin
      cyc(0, none);
      chk("stall_hold_index", 32'(si), 32'd1);
      chk("stall_hold_data", sd, 32'h101);
    end
    sr = 1'b1;
    cyc(0, none);
    cyc(0, none);

    // Reset with a full buffer discards both words
    rv = 3'b111;
    sr = 1'b0;
    cyc(0, none);
    cyc(0, none);
    rst = 1'b1;
    cyc(0, none);
    rst = 1'b0;
    rv  = 3'b000;
    sr  = 1'b1;
    chk("midreset_send_valid", 32'(sv), 32'd0);
    chk("midreset_send_data", sd, 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, none);

    // Random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      rv = N'($urandom_range(0, (1 << N) - 1));
      sr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) rd[DW*i +: DW] = $urandom;
      cyc(0, none);
    end
    rv = 3'b000;
    sr = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, none);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_send_valid", 32'(sv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/connect_merge_rr.md
# connect_merge_rr

Round-robin N-to-1 stream merger with a 2-entry output buffer. It shares a single downstream consumer between `CONNECT_NUM` upstream producers, the inverse of the fork that distributes one stream to many. Every accepted word is tagged with the index of the input it came from, so downstream logic can route responses back. Outputs are registered, and sustained throughput is one word per cycle.

## Interface
- `DATA_WIDTH`, 32, payload width per channel
- `CONNECT_NUM`, 3, number of upstream producers (≥2)
- `INDEX_WIDTH`, 2, width of source tag; must satisfy 2^INDEX_WIDTH ≥ CONNECT_NUM
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `RECEIVE_VALID`  in  CONNECT_NUM  per-producer valid
- `RECEIVE_DATA`  in  DATA_WIDTH*CONNECT_NUM  producer i data at bits [DATA_WIDTH*i +: DATA_WIDTH]
- `RECEIVE_READY`  out  CONNECT_NUM  one-hot or zero; high only for the granted producer
- `SEND_VALID`  out  1  buffer head valid
- `SEND_DATA`  out  DATA_WIDTH  buffer head data
- `SEND_INDEX`  out  INDEX_WIDTH  source index of head word
- `SEND_READY`  in  1  consumer ready

## Operation
- Transfer on any channel happens on a rising edge when VALID and READY are both high.
- State:
  - `ptr`: round-robin pointer, 0..CONNECT_NUM-1
  - `count`: occupancy, 0..2
  - two entries of {data, index}, organized as head/tail
- Space: `space = (count < 2)`.
- Grant (combinational):
  - `grant` = first i with `RECEIVE_VALID[i]`=1, scanning ptr, ptr+1, …, wrapping modulo CONNECT_NUM.
  - `any` = OR of `RECEIVE_VALID`.
- Ready: `RECEIVE_READY[grant] = space & any & ~RST`; all other bits 0.
- Push, when `space & any`:
  - write {`RECEIVE_DATA` slice of `grant`, `grant`} into the next free entry.
  - set `ptr` ← (grant+1) mod CONNECT_NUM. The wrap is computed explicitly; no power-of-two assumption.
- Pop, when `SEND_VALID & SEND_READY`: advance head.
- Count update:
  - push only → `count` +1
  - pop only → `count` -1
  - push and pop together → `count` unchanged; head advances and new word goes to tail.
- `ptr` does not move on cycles without a push. Idle producers never consume a turn.
- Fairness: a continuously asserting producer waits at most CONNECT_NUM-1 pushes between grants.
- Ordering: words leave in acceptance order. No reordering, no drops, no duplication.
- Once `SEND_VALID`=1, `SEND_DATA` and `SEND_INDEX` are held stable until popped.

## Timing
- Reset values, on the first edge with `RST`=1:
  - `count`=0, `ptr`=0, both entries' data/index=0
  - `SEND_VALID`=0, `SEND_DATA`=0, `SEND_INDEX`=0
- `RECEIVE_READY`=0 throughout the reset cycle(s).
- Reset mid-operation discards buffered words. No handshake completes in a reset cycle.
- Latency: a word accepted at edge k appears on `SEND_*` after edge k when the buffer was empty. Otherwise it appears behind older words.
- Throughput:
  - with `SEND_READY` held high and any producer valid, one push and one pop per cycle; `count` stays at 1.
  - `count`=2 deasserts all `RECEIVE_READY`. A pop in that cycle frees space only for the next cycle, so no combinational path exists from `SEND_READY` to `RECEIVE_READY`.
- `RECEIVE_READY` depends combinationally on `RECEIVE_VALID`, `ptr` and `count`. Producers must not make VALID depend on READY.
- `SEND_*` are driven purely from registers.

## Structure
- Shared package `connect_pkg`:
  - `clog2` function
  - default `DATA_WIDTH` constant, shared with the fork
- Sub-module `connect_rr_pick`: combinational, parameter `CONNECT_NUM`. Inputs `req`, `ptr`; outputs `grant`, `any`. It is reused by the future scheduler blocks.
- Buffer and pointer logic live in the top module.

## Test plan
- Reset: assert `RST` 2 cycles with all `RECEIVE_VALID`=3'b111 → `RECEIVE_READY`=0, `SEND_VALID`=0, `SEND_INDEX`=0. After release, first grant is input 0.
- Round-robin: `RECEIVE_VALID`=3'b111 held, `SEND_READY`=1, data_i=0x100+i → `SEND_INDEX` sequence 0,1,2,0,1,2. One word per cycle. `count` never exceeds 1.
- Skip idle: only inputs 0 and 2 valid → grants alternate 0,2,0,2. Ptr wraps 2→0.
- Backpressure: `SEND_READY`=0, all inputs valid → exactly 2 words (index 0, 1) accepted, then `RECEIVE_READY`=0. Raise `SEND_READY` → words pop in order 0x100, 0x101, followed by input 2.
- Stability: hold `SEND_READY`=0 for 5 cycles with `count`=1 → `SEND_DATA`/`SEND_INDEX` are unchanged every cycle.
- Mid-reset: `count`=2 with words pending, assert `RST` 1 cycle → `SEND_VALID`=0 next cycle, and the pending words never appear. Scoreboard checks no drops or duplicates across 10k random valid/ready cycles.
